// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and framing constants.
package uart_pkg;
    localparam int UART_DATA_BITS = 8;
    localparam int UART_MIN_DIV   = 4;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A pop and a push in the same cycle on a full FIFO both succeed; a pop on an empty FIFO is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr, r_wr_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_data, w_head_nxt;
    logic [AW-1:0]    w_rd_nxt;
    logic             w_empty, w_full, w_do_pop, w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign w_rd_nxt  = r_rd_ptr + AW'(1);
    assign o_drop    = i_push && w_full && !i_pop;
    assign o_data    = r_data;
    assign o_count   = r_count;

    // Registered head so the output holds its last value once the FIFO drains
    always_comb begin
        w_head_nxt = r_data;
        if (w_do_pop) begin
            if (r_count == (AW+1)'(1)) begin
                if (w_do_push) w_head_nxt = i_data;
            end else begin
                w_head_nxt = r_mem[w_rd_nxt];
            end
        end else if (w_empty && w_do_push) begin
            w_head_nxt = i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_data   <= '0;
        end else begin
            if (w_do_pop)  r_rd_ptr <= w_rd_nxt;
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            r_count <= r_count + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
            r_data  <= w_head_nxt;
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with input synchroniser, mid-bit sampling FSM and byte FIFO.
// Reports sticky framing and overrun errors.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_in,
    input  logic [DIV_WIDTH-1:0]          divisor,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [7:0]                    rd_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun_err,
    output logic                          busy
);
    uart_rx_state_t r_state, w_state_nxt;
    logic                      r_sync1, r_sync2, r_line_prev;
    logic [DIV_WIDTH-1:0]      r_cnt, w_cnt_nxt, r_div, w_div_nxt, w_div_eff;
    logic [2:0]                r_bit, w_bit_nxt;
    logic [UART_DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic                      r_push, w_push_nxt;
    logic                      r_frame_err, r_overrun_err;
    logic                      w_fe_set, w_drop, w_sample, w_fall, w_line;

    assign w_line    = r_sync2;
    assign w_fall    = r_line_prev && !r_sync2;
    assign w_sample  = (r_cnt == '0);
    assign w_div_eff = (divisor < DIV_WIDTH'(UART_MIN_DIV)) ? DIV_WIDTH'(UART_MIN_DIV) : divisor;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_line_prev <= 1'b1;
        end else begin
            r_sync1     <= rx_in;
            r_sync2     <= r_sync1;
            r_line_prev <= r_sync2;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_div_nxt   = r_div;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_push_nxt  = 1'b0;
        w_fe_set    = 1'b0;
        if (r_state != IDLE) w_cnt_nxt = w_sample ? (r_div - DIV_WIDTH'(1)) : (r_cnt - DIV_WIDTH'(1));
        case (r_state)
            IDLE: begin
                // Half-bit preload puts the first sample in the middle of the start bit
                if (w_fall) begin
                    w_div_nxt   = w_div_eff;
                    w_cnt_nxt   = (w_div_eff >> 1) - DIV_WIDTH'(1);
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_sample) begin
                    if (w_line) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = DATA;
                        w_bit_nxt   = '0;
                    end
                end
            end
            DATA: begin
                if (w_sample) begin
                    w_shift_nxt = {w_line, r_shift[UART_DATA_BITS-1:1]};
                    w_bit_nxt   = r_bit + 3'(1);
                    if (r_bit == 3'(UART_DATA_BITS-1)) w_state_nxt = STOP;
                end
            end
            STOP: begin
                if (w_sample) begin
                    w_state_nxt = IDLE;
                    if (w_line) w_push_nxt = 1'b1;
                    else        w_fe_set   = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_div         <= DIV_WIDTH'(UART_MIN_DIV);
            r_bit         <= '0;
            r_shift       <= '0;
            r_push        <= 1'b0;
            r_frame_err   <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_div         <= w_div_nxt;
            r_bit         <= w_bit_nxt;
            r_shift       <= w_shift_nxt;
            r_push        <= w_push_nxt;
            r_frame_err   <= w_fe_set | (r_frame_err & ~err_clr);
            r_overrun_err <= w_drop   | (r_overrun_err & ~err_clr);
        end
    end

    // The shift register stays stable in IDLE, so it feeds the FIFO directly on the push cycle
    sync_fifo #(.WIDTH(UART_DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_push),
        .i_data  (r_shift),
        .i_pop   (rd_en),
        .o_data  (rd_data),
        .o_count (fifo_count),
        .o_drop  (w_drop)
    );

    assign rx_valid    = (fifo_count != '0);
    assign frame_err   = r_frame_err;
    assign overrun_err = r_overrun_err;
    assign busy        = (r_state != IDLE);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table, directed corner sequences and
// randomized frames checked against a queue-based model of the receive FIFO.
module tb_uart_rx_fifo;
    localparam int DEPTH = 4;
    localparam int DW    = 16;
    localparam int OP_F  = 0;
    localparam int OP_P  = 1;
    localparam int OP_C  = 2;

    logic          clk = 1'b0;
    logic          rst_n, rx_in, rd_en, err_clr;
    logic [DW-1:0] divisor;
    logic [7:0]    rd_data;
    logic          rx_valid, frame_err, overrun_err, busy;
    logic [$clog2(DEPTH):0] fifo_count;

    uart_rx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .divisor(divisor), .rd_en(rd_en),
        .err_clr(err_clr), .rd_data(rd_data), .rx_valid(rx_valid), .fifo_count(fifo_count),
        .frame_err(frame_err), .overrun_err(overrun_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    bit         m_fe, m_oe;
    logic [7:0] m_last;

    typedef struct {
        int         op;
        logic [7:0] data;
        bit         stop;
        int         div;
        int         exp_cnt;
        logic [7:0] exp_head;
        bit         exp_fe;
        bit         exp_oe;
    } vec_t;
    vec_t vt[$];

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fe = 0; m_oe = 0; m_last = 8'h00;
    endtask

    task automatic model_frame(input logic [7:0] d, input bit stop);
        if (!stop) m_fe = 1;
        else if (mq.size() < DEPTH) mq.push_back(d);
        else m_oe = 1;
        if (mq.size() > 0) m_last = mq[0];
    endtask

    task automatic model_pop();
        if (mq.size() > 0) void'(mq.pop_front());
        if (mq.size() > 0) m_last = mq[0];
    endtask

    task automatic check_model(input string nm);
        chk({nm, ".count"}, 32'(fifo_count), 32'(mq.size()));
        chk({nm, ".valid"}, 32'(rx_valid), 32'(mq.size() != 0));
        chk({nm, ".data"},  32'(rd_data), 32'(m_last));
        chk({nm, ".ferr"},  32'(frame_err), 32'(m_fe));
        chk({nm, ".oerr"},  32'(overrun_err), 32'(m_oe));
        chk({nm, ".busy"},  32'(busy), 32'(0));
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop, input int bc);
        rx_in = 1'b0;
        tick(bc);
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            tick(bc);
        end
        rx_in = stop;
        tick(bc);
        rx_in = 1'b1;
    endtask

    task automatic do_frame(input logic [7:0] d, input bit stop, input int div);
        int bc;
        bc = (div < 4) ? 4 : div;
        divisor = DW'(div);
        send_frame(d, stop, bc);
        tick(2 * bc + 10);
        model_frame(d, stop);
    endtask

    task automatic do_pop();
        rd_en = 1'b1; tick(1); rd_en = 1'b0; tick(2);
        model_pop();
    endtask

    task automatic do_clr();
        err_clr = 1'b1; tick(1); err_clr = 1'b0; tick(1);
        m_fe = 0; m_oe = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(2);
        model_reset();
    endtask

    // Pulses rd_en in the cycle right after busy drops, i.e. the push cycle
    task automatic frame_with_pop(input logic [7:0] d);
        bit ok;
        ok = 0;
        divisor = DW'(16);
        fork
            send_frame(d, 1'b1, 16);
            begin
                int c;
                c = 0;
                while (!busy && c < 50) begin tick(1); c++; end
                while (busy && c < 300) begin tick(1); c++; end
                ok = !busy && (c < 300);
                rd_en = 1'b1; tick(1); rd_en = 1'b0;
            end
        join
        chk("pop_push_window", 32'(ok), 32'(1));
        tick(20);
        model_pop();
        model_frame(d, 1'b1);
    endtask

    initial begin
        int lat;
        rst_n = 1'b0; rx_in = 1'b1; divisor = DW'(16); rd_en = 1'b0; err_clr = 1'b0;
        model_reset();
        tick(3);
        chk("rst.rd_data", 32'(rd_data), 0);
        chk("rst.rx_valid", 32'(rx_valid), 0);
        chk("rst.count", 32'(fifo_count), 0);
        chk("rst.ferr", 32'(frame_err), 0);
        chk("rst.oerr", 32'(overrun_err), 0);
        chk("rst.busy", 32'(busy), 0);
        rst_n = 1'b1;
        tick(3);

        // single byte with latency bound from the start edge
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1, 16);
            begin
                while (!rx_valid && lat < 200) begin tick(1); lat++; end
            end
        join
        chk("a5_latency", 32'(lat <= 16 * 10 + 4), 32'(1));
        model_frame(8'hA5, 1'b1);
        tick(20);
        check_model("a5");
        do_pop();
        check_model("a5_pop");

        // start-bit glitch
        rx_in = 1'b0; tick(3); rx_in = 1'b1; tick(2);
        chk("glitch.busy_hi", 32'(busy), 32'(1));
        tick(20);
        check_model("glitch");

        // vector table
        do_reset();
        vt.push_back('{OP_F, 8'h3C, 1'b0, 16, 0, 8'h00, 1'b1, 1'b0});
        vt.push_back('{OP_C, 8'h00, 1'b1, 16, 0, 8'h00, 1'b0, 1'b0});
        vt.push_back('{OP_F, 8'h55, 1'b1, 16, 1, 8'h55, 1'b0, 1'b0});
        vt.push_back('{OP_P, 8'h00, 1'b1, 16, 0, 8'h55, 1'b0, 1'b0});
        vt.push_back('{OP_F, 8'h01, 1'b1, 16, 1, 8'h01, 1'b0, 1'b0});
        vt.push_back('{OP_F, 8'h02, 1'b1, 16, 2, 8'h01, 1'b0, 1'b0});
        vt.push_back('{OP_F, 8'h03, 1'b1, 16, 3, 8'h01, 1'b0, 1'b0});
        vt.push_back('{OP_F, 8'h04, 1'b1, 16, 4, 8'h01, 1'b0, 1'b0});
        vt.push_back('{OP_F, 8'h05, 1'b1, 16, 4, 8'h01, 1'b0, 1'b1});
        vt.push_back('{OP_P, 8'h00, 1'b1, 16, 3, 8'h02, 1'b0, 1'b1});
        vt.push_back('{OP_P, 8'h00, 1'b1, 16, 2, 8'h03, 1'b0, 1'b1});
        vt.push_back('{OP_P, 8'h00, 1'b1, 16, 1, 8'h04, 1'b0, 1'b1});
        vt.push_back('{OP_P, 8'h00, 1'b1, 16, 0, 8'h04, 1'b0, 1'b1});
        vt.push_back('{OP_F, 8'h81, 1'b1,  2, 1, 8'h81, 1'b0, 1'b1});
        vt.push_back('{OP_P, 8'h00, 1'b1, 16, 0, 8'h81, 1'b0, 1'b1});
        vt.push_back('{OP_C, 8'h00, 1'b1, 16, 0, 8'h81, 1'b0, 1'b0});
        vt.push_back('{OP_P, 8'h00, 1'b1, 16, 0, 8'h81, 1'b0, 1'b0});
        for (int i = 0; i < vt.size(); i++) begin
            case (vt[i].op)
                OP_F:    do_frame(vt[i].data, vt[i].stop, vt[i].div);
                OP_P:    do_pop();
                default: do_clr();
            endcase
            chk($sformatf("vec%0d.count", i), 32'(fifo_count), 32'(vt[i].exp_cnt));
            chk($sformatf("vec%0d.valid", i), 32'(rx_valid), 32'(vt[i].exp_cnt != 0));
            chk($sformatf("vec%0d.data", i),  32'(rd_data), 32'(vt[i].exp_head));
            chk($sformatf("vec%0d.ferr", i),  32'(frame_err), 32'(vt[i].exp_fe));
            chk($sformatf("vec%0d.oerr", i),  32'(overrun_err), 32'(vt[i].exp_oe));
        end

        // pop and push together at full, then at empty
        do_reset();
        for (int i = 0; i < DEPTH; i++) do_frame(8'h11 * (i + 1), 1'b1, 16);
        check_model("full");
        frame_with_pop(8'h99);
        check_model("full_poppush");
        for (int i = 0; i < DEPTH; i++) begin
            do_pop();
            check_model("drain");
        end
        frame_with_pop(8'h66);
        check_model("empty_poppush");

        // divisor change mid-frame only affects the next frame
        divisor = DW'(16);
        fork
            send_frame(8'h5A, 1'b1, 16);
            begin tick(50); divisor = DW'(32); end
        join
        tick(40);
        model_frame(8'h5A, 1'b1);
        check_model("div_mid");
        do_frame(8'hC3, 1'b1, 32);
        check_model("div_32");

        // break: line held low past the stop bit yields one framing error only
        divisor = DW'(16);
        rx_in = 1'b0; tick(16 * 14); rx_in = 1'b1; tick(40);
        model_frame(8'h00, 1'b0);
        check_model("break");
        do_clr();
        check_model("break_clr");

        // reset during data bit 4
        fork
            send_frame(8'hFF, 1'b1, 16);
            begin
                tick(16 * 5 + 8);
                rst_n = 1'b0;
                tick(2);
                chk("midrst.rd_data", 32'(rd_data), 0);
                chk("midrst.rx_valid", 32'(rx_valid), 0);
                chk("midrst.count", 32'(fifo_count), 0);
                chk("midrst.ferr", 32'(frame_err), 0);
                chk("midrst.oerr", 32'(overrun_err), 0);
                chk("midrst.busy", 32'(busy), 0);
            end
        join
        tick(10);
        rst_n = 1'b1;
        model_reset();
        tick(5);
        check_model("post_rst");
        do_frame(8'hF0, 1'b1, 16);
        check_model("after_rst_f0");

        // randomized traffic against the model
        do_reset();
        for (int n = 0; n < 30; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 6) do_frame(8'($urandom), ($urandom_range(0, 5) != 0), int'($urandom_range(0, 10)));
            else if (r < 9) do_pop();
            else do_clr();
            check_model($sformatf("rnd%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
